// File: rtl/aes128_round_ctrl_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 round controller.
// Blocks are kept in row-major layout: byte (r,c) sits at bits [127-32r-8c -: 8].
package aes128_round_ctrl_pkg;

    localparam int AES_NR     = 10;
    localparam int AES_KIDX_W = 4;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic block_t mix_columns(input block_t s, input logic inv);
        block_t     o;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*c -: 8];
            a1 = s[95-8*c -: 8];
            a2 = s[63-8*c -: 8];
            a3 = s[31-8*c -: 8];
            if (!inv) begin
                o[127-8*c -: 8] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                o[95-8*c -: 8]  = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                o[63-8*c -: 8]  = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                o[31-8*c -: 8]  = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
            end else begin
                o[127-8*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
                o[95-8*c -: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
                o[63-8*c -: 8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
                o[31-8*c -: 8]  = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_round_ctrl_round.sv
// Combinational AES round: forward is Sub/Shift/Mix/AddKey, inverse is
// InvShift/InvSub/AddKey/InvMix so decrypt can walk the encrypt key schedule backwards.
module aes128_round_ctrl_round
    import aes128_round_ctrl_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    input  logic         enc_or_dec_i,
    input  logic         mix_col_i,
    output logic [127:0] state_o
);

    block_t fwd_sub;
    block_t fwd_mix;
    block_t inv_sub;
    block_t inv_key;
    block_t inv_mix;

    // Row shifts are folded into the byte select feeding each S-box.
    always_comb begin
        fwd_sub = '0;
        inv_sub = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                fwd_sub[127-32*r-8*c -: 8] = sbox(state_i[127-32*r-8*((c+r)%4) -: 8]);
                inv_sub[127-32*r-8*c -: 8] = inv_sbox(state_i[127-32*r-8*((c+4-r)%4) -: 8]);
            end
        end
    end

    assign fwd_mix = mix_col_i ? mix_columns(fwd_sub, 1'b0) : fwd_sub;
    assign inv_key = inv_sub ^ key_i;
    assign inv_mix = mix_col_i ? mix_columns(inv_key, 1'b1) : inv_key;
    assign state_o = enc_or_dec_i ? (fwd_mix ^ key_i) : inv_mix;

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 round controller: one round per cycle, round keys fetched by index.
// Decrypt support is enabled by defining AES_DECRYPT_EN; otherwise every block is encrypted.
module aes128_round_ctrl
    import aes128_round_ctrl_pkg::*;
#(
    parameter int NR     = AES_NR,
    parameter int KIDX_W = AES_KIDX_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [127:0]      in_data_i,
    input  logic              enc_or_dec_i,
    output logic [KIDX_W-1:0] rk_idx_o,
    input  logic [127:0]      rk_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [127:0]      out_data_o,
    output logic              busy_o
);

    localparam logic [KIDX_W-1:0] NR_K  = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] ONE_K = KIDX_W'(1);

    state_e            fsm_q;
    block_t            state_q;
    logic [KIDX_W-1:0] cnt_q;
    logic              mode_q;
    logic              mode_in;
    logic              mix_col;
    block_t            round_out;

`ifdef AES_DECRYPT_EN
    assign mode_in = enc_or_dec_i;
`else
    logic unused_enc_or_dec;
    assign unused_enc_or_dec = enc_or_dec_i;
    assign mode_in           = 1'b1;
`endif

    assign mix_col    = (cnt_q != NR_K);
    assign out_data_o = state_q;

    aes128_round_ctrl_round round (
        .state_i      (state_q),
        .key_i        (rk_i),
        .enc_or_dec_i (mode_q),
        .mix_col_i    (mix_col),
        .state_o      (round_out)
    );

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and a presented block holds until it transfers.
    // rk_idx_o is registered one step ahead so the key store sees it for the whole cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b1;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            rk_idx_o    <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        state_q    <= in_data_i;
                        mode_q     <= mode_in;
                        cnt_q      <= '0;
                        rk_idx_o   <= mode_in ? '0 : NR_K;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        fsm_q      <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    state_q  <= state_q ^ rk_i;
                    cnt_q    <= ONE_K;
                    rk_idx_o <= mode_q ? ONE_K : NR_K - ONE_K;
                    fsm_q    <= ST_ROUND;
                end
                ST_ROUND: begin
                    state_q <= round_out;
                    if (cnt_q == NR_K) begin
                        rk_idx_o    <= '0;
                        out_valid_o <= 1'b1;
                        fsm_q       <= ST_DONE;
                    end else begin
                        cnt_q    <= cnt_q + ONE_K;
                        rk_idx_o <= mode_q ? cnt_q + ONE_K : NR_K - cnt_q - ONE_K;
                    end
                end
                ST_DONE: begin
                    // No accept here even if the output transfers this edge.
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        in_ready_o  <= 1'b1;
                        fsm_q       <= ST_IDLE;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl using FIPS-197 C.1 vectors (transposed to row-major).
// Decrypt checks are built in when AES_DECRYPT_EN is defined.
module tb_aes128_round_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] in_data_i;
    logic         enc_or_dec_i;
    logic [3:0]   rk_idx_o;
    logic [127:0] rk_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] out_data_o;
    logic         busy_o;

    int n_pass  = 0;
    int n_total = 0;

    logic [127:0] rk_tab [0:10];
    logic [127:0] pt_rm;
    logic [127:0] ct_rm;
    logic [127:0] exp_q [$];

    int unsigned  cyc = 0;
    int unsigned  acc_q [$];
    int unsigned  hs_q [$];
    int unsigned  rise_q [$];
    logic [127:0] hs_data_q [$];
    logic [3:0]   rk_log [$];
    logic         prev_valid = 1'b0;

    aes128_round_ctrl dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .enc_or_dec_i (enc_or_dec_i),
        .rk_idx_o     (rk_idx_o),
        .rk_i         (rk_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .busy_o       (busy_o)
    );

    // ---------------- clock / reset / key store ----------------
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always_comb begin
        rk_i = '0;
        if (rk_idx_o <= 4'd10) rk_i = rk_tab[rk_idx_o];
    end

    // Event log sampled mid-cycle; inputs only change just after rising edges.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (in_valid_i && in_ready_o) acc_q.push_back(cyc);
            if (out_valid_o && out_ready_i) begin
                hs_q.push_back(cyc);
                hs_data_q.push_back(out_data_o);
            end
            if (out_valid_o && !prev_valid) rise_q.push_back(cyc);
            if (busy_o && !out_valid_o) rk_log.push_back(rk_idx_o);
        end
        prev_valid <= out_valid_o;
    end

    function automatic logic [127:0] tp(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                y[127-32*r-8*c -: 8] = x[127-8*(r+4*c) -: 8];
        return y;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        acc_q.delete();
        hs_q.delete();
        rise_q.delete();
        hs_data_q.delete();
        rk_log.delete();
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic drive_block(input logic [127:0] d, input logic m);
        int waited;
        waited       = 0;
        in_valid_i   = 1'b1;
        in_data_i    = d;
        enc_or_dec_i = m;
        while (!in_ready_o && waited < 40) begin
            @(posedge clk_i); #1;
            waited++;
        end
        if (!in_ready_o) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready_o=%b after %0d cycles, required 1", in_ready_o, waited);
        end
        @(posedge clk_i); #1;
        in_valid_i   = 1'b0;
        in_data_i    = {$urandom(), $urandom(), $urandom(), $urandom()};
        enc_or_dec_i = ~m;
    endtask

    task automatic wait_valid();
        int waited;
        waited = 0;
        while (!out_valid_o && waited < 40) begin
            @(posedge clk_i); #1;
            waited++;
        end
        if (!out_valid_o) begin
            n_total++;
            $display("FAIL valid_timeout: out_valid_o=%b after %0d cycles, required 1", out_valid_o, waited);
        end
    endtask

    task automatic consume();
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n_i      = 1'b0;
        in_valid_i   = 1'b0;
        in_data_i    = '0;
        enc_or_dec_i = 1'b1;
        out_ready_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_total++; if (in_ready_o !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", in_ready_o); else n_pass++;
        n_total++; if (out_valid_o !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy_o); else n_pass++;
        n_total++; if (rk_idx_o !== 4'd0) $display("FAIL rst_rk_idx: got %0d required 0", rk_idx_o); else n_pass++;
        n_total++; if (out_data_o !== 128'h0) $display("FAIL rst_out_data: got %h required 0", out_data_o); else n_pass++;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic run_and_check(input string name, input logic [127:0] din, input logic m,
                                 input logic [127:0] dexp, input logic up);
        logic [127:0] e;
        int           lat;
        logic         seq_ok;
        clear_logs();
        exp_q.push_back(dexp);
        drive_block(din, m);
        wait_valid();
        consume();
        lat = (rise_q.size() > 0 && acc_q.size() > 0) ? int'(rise_q[0] - acc_q[0]) : -1;
        n_total++;
        if (lat != 12) $display("FAIL %s_latency: got %0d required 12", name, lat); else n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if (hs_data_q.size() != 1 || hs_data_q[0] !== e)
            $display("FAIL %s_data: got %h (count %0d) required %h", name,
                     (hs_data_q.size() > 0) ? hs_data_q[0] : 128'h0, hs_data_q.size(), e);
        else n_pass++;
        seq_ok = (rk_log.size() == 11);
        for (int i = 0; i < rk_log.size() && i < 11; i++)
            if (rk_log[i] !== (up ? 4'(i) : 4'(10 - i))) seq_ok = 1'b0;
        n_total++;
        if (!seq_ok) $display("FAIL %s_rk_seq: got %p required %s", name, rk_log, up ? "0..10" : "10..0");
        else n_pass++;
        n_total++;
        if (in_ready_o !== 1'b1 || busy_o !== 1'b0 || rk_idx_o !== 4'd0)
            $display("FAIL %s_back_idle: got ready=%b busy=%b idx=%0d required 1,0,0", name, in_ready_o, busy_o, rk_idx_o);
        else n_pass++;
    endtask

    task automatic test_encrypt();
        run_and_check("enc", pt_rm, 1'b1, ct_rm, 1'b1);
    endtask

`ifdef AES_DECRYPT_EN
    task automatic test_decrypt();
        run_and_check("dec", ct_rm, 1'b0, pt_rm, 1'b0);
    endtask
`else
    task automatic test_mode_ignored();
        run_and_check("mode0", pt_rm, 1'b0, ct_rm, 1'b1);
    endtask
`endif

    task automatic test_hold();
        logic [127:0] e;
        clear_logs();
        exp_q.push_back(ct_rm);
        drive_block(pt_rm, 1'b1);
        wait_valid();
        e = exp_q.pop_front();
        in_valid_i = 1'b1;
        in_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (out_valid_o !== 1'b1 || out_data_o !== e || in_ready_o !== 1'b0 || busy_o !== 1'b1)
                $display("FAIL hold_c%0d: got v=%b d=%h rdy=%b busy=%b required 1,%h,0,1",
                         i, out_valid_o, out_data_o, in_ready_o, busy_o, e);
            else n_pass++;
            @(posedge clk_i); #1;
        end
        consume();
        in_valid_i = 1'b0;
        n_total++;
        if (acc_q.size() != 1) $display("FAIL hold_no_accept_in_done: got %0d accepts required 1", acc_q.size());
        else n_pass++;
        n_total++;
        if (hs_data_q.size() != 1 || in_ready_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL hold_release: got hs=%0d rdy=%b busy=%b required 1,1,0", hs_data_q.size(), in_ready_o, busy_o);
        else n_pass++;
        repeat (2) @(posedge clk_i); #1;
        clear_logs();
    endtask

    task automatic test_back_to_back();
        logic [127:0] e;
        int           waited;
        clear_logs();
        exp_q.push_back(ct_rm);
        exp_q.push_back(ct_rm);
        out_ready_i  = 1'b1;
        in_valid_i   = 1'b1;
        in_data_i    = pt_rm;
        enc_or_dec_i = 1'b1;
        waited = 0;
        while (acc_q.size() < 2 && waited < 60) begin
            @(posedge clk_i); #1;
            waited++;
        end
        in_valid_i = 1'b0;
        waited = 0;
        while (hs_q.size() < 2 && waited < 40) begin
            @(posedge clk_i); #1;
            waited++;
        end
        out_ready_i = 1'b0;
        n_total++;
        if (acc_q.size() != 2 || hs_q.size() != 2)
            $display("FAIL b2b_counts: got acc=%0d hs=%0d required 2,2", acc_q.size(), hs_q.size());
        else n_pass++;
        n_total++;
        if (acc_q.size() < 2 || hs_q.size() < 1 || acc_q[1] != hs_q[0] + 1)
            $display("FAIL b2b_accept_gap: got acc=%p hs=%p required second accept one cycle after first handshake", acc_q, hs_q);
        else n_pass++;
        n_total++;
        if (acc_q.size() < 2 || acc_q[1] - acc_q[0] != 13)
            $display("FAIL b2b_period: got acc=%p required spacing 13", acc_q);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_total++;
            if (hs_data_q.size() <= i || hs_data_q[i] !== e)
                $display("FAIL b2b_data%0d: got %h required %h", i, (hs_data_q.size() > i) ? hs_data_q[i] : 128'h0, e);
            else n_pass++;
        end
        repeat (2) @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid();
        clear_logs();
        drive_block(pt_rm, 1'b1);
        repeat (5) @(posedge clk_i);
        #1;
        n_total++;
        if (rk_idx_o !== 4'd5 || busy_o !== 1'b1)
            $display("FAIL mid_pre_reset: got idx=%0d busy=%b required 5,1", rk_idx_o, busy_o);
        else n_pass++;
        #2 rst_n_i = 1'b0;
        #1;
        n_total++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || rk_idx_o !== 4'd0 || out_data_o !== 128'h0)
            $display("FAIL mid_reset: got rdy=%b v=%b busy=%b idx=%0d d=%h required 1,0,0,0,0",
                     in_ready_o, out_valid_o, busy_o, rk_idx_o, out_data_o);
        else n_pass++;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        run_and_check("post_rst", pt_rm, 1'b1, ct_rm, 1'b1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        pt_rm     = tp(128'h00112233445566778899aabbccddeeff);
        ct_rm     = tp(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        rk_tab[0]  = tp(128'h000102030405060708090a0b0c0d0e0f);
        rk_tab[1]  = tp(128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        rk_tab[2]  = tp(128'hb692cf0b643dbdf1be9bc5006830b3fe);
        rk_tab[3]  = tp(128'hb6ff744ed2c2c9bf6c590cbf0469bf41);
        rk_tab[4]  = tp(128'h47f7f7bc95353e03f96c32bcfd058dfd);
        rk_tab[5]  = tp(128'h3caaa3e8a99f9deb50f3af57adf622aa);
        rk_tab[6]  = tp(128'h5e390f7df7a69296a7553dc10aa31f6b);
        rk_tab[7]  = tp(128'h14f9701ae35fe28c440adf4d4ea9c026);
        rk_tab[8]  = tp(128'h47438735a41c65b9e016baf4aebf7ad2);
        rk_tab[9]  = tp(128'h549932d1f08557681093ed9cbe2c974e);
        rk_tab[10] = tp(128'h13111d7fe3944a17f307a78b4d2b30c5);

        test_reset();
        test_encrypt();
`ifdef AES_DECRYPT_EN
        test_decrypt();
`else
        test_mode_ignored();
`endif
        test_hold();
        test_back_to_back();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes128_round_ctrl.md
AES128_ROUND_CTRL -- requirements
Module: aes128_round_ctrl

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds; only 10 is supported.
REQ-002 Parameter KIDX_W, default 4, width of the round-key index.
REQ-003 clk_i  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 in_valid_i  input  1  input block and mode are valid.
REQ-006 in_ready_o  output  1  controller can accept a block.
REQ-007 in_data_i  input  128  input block in row-major state layout: byte (r,c) at bits [127-32r-8c -: 8].
REQ-008 enc_or_dec_i  input  1  mode: 1 selects encrypt, 0 selects decrypt; sampled at accept.
REQ-009 rk_idx_o  output  KIDX_W  index of the round key requested from the external key store.
REQ-010 rk_i  input  128  round key for rk_idx_o, returned combinationally in the same cycle.
REQ-011 out_valid_o  output  1  out_data_o holds a finished block.
REQ-012 out_ready_i  input  1  downstream consumes the output.
REQ-013 out_data_o  output  128  result block, same layout as in_data_i.
REQ-014 busy_o  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, INIT, ROUND and DONE.
REQ-016 In IDLE, in_ready_o=1; on in_valid_i&in_ready_o, latch in_data_i into the state register, latch the mode, clear the round counter and go to INIT.
REQ-017 INIT (1 cycle): state <= state ^ rk_i; rk_idx_o = 0 (encrypt) or NR (decrypt); go to ROUND with counter=1.
REQ-018 ROUND (NR cycles): state <= round datapath output; rk_idx_o = counter (encrypt) or NR-counter (decrypt).
REQ-019 ROUND: mix_col is driven 1 while counter<NR and 0 on the final round (counter=NR).
REQ-020 ROUND: when counter=NR, go to DONE; otherwise increment the counter.
REQ-021 DONE: out_valid_o=1 and out_data_o=state; both are held stable until out_ready_i; on out_valid_o&out_ready_i go to IDLE.
REQ-022 Latency SHALL be NR+2 cycles from the accept edge to out_valid_o high (12 for NR=10).
REQ-023 in_ready_o SHALL be 0 outside IDLE; input is never accepted during DONE, even in the same cycle as the output handshake.
REQ-024 Throughput: at most one block per NR+3 cycles with out_ready_i held high.
REQ-025 rk_idx_o SHALL be 0 in IDLE and DONE.
REQ-026 Mode and in_data_i changes after accept SHALL NOT affect the block in flight.
REQ-027 out_ready_i asserted while out_valid_o=0 SHALL be ignored.
REQ-028 The round counter SHALL be KIDX_W bits wide and never exceed NR.

Reset
REQ-029 Asserting rst_n_i, including mid-operation, SHALL go to IDLE and drop any in-flight block.
REQ-030 Reset values: state register=0, counter=0, mode=1, in_ready_o=1, out_valid_o=0, busy_o=0, rk_idx_o=0, out_data_o=0.

Configuration
REQ-031 Macro AES_DECRYPT_EN: when defined, enc_or_dec_i is honoured as in REQ-008.
REQ-032 Without AES_DECRYPT_EN, the latched mode is tied to 1, enc_or_dec_i is ignored, and a block presented with enc_or_dec_i=0 is encrypted.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the NR=10 and KIDX_W=4 constants, and the 128-bit block typedef.
REQ-034 A single sub-module is instantiated: the existing combinational round datapath "round".
REQ-035 Connections to "round": state_i = state register, key_i = rk_i, enc_or_dec_i = latched mode, mix_col_i = per REQ-019.

Verification
REQ-036 FIPS-197 C.1 encrypt, key 000102..0f, pt 00112233..eeff (transposed to row-major) -> out 69c4e0d86a7b0430d8cdb78070b4c55a (transposed), out_valid_o at cycle 12; rk_idx_o sequence 0,1..10.
REQ-037 Same key, decrypt of 69c4..c55a with AES_DECRYPT_EN defined -> out 00112233..eeff; rk_idx_o sequence 10,9..0.
REQ-038 out_ready_i held low for 5 cycles in DONE -> out_data_o stable, in_ready_o=0 and busy_o=1 throughout; the output handshake then returns to IDLE.
REQ-039 Two blocks back-to-back with in_valid_i held high -> second accept occurs exactly 1 cycle after the first output handshake; both results correct.
REQ-040 rst_n_i pulsed low during ROUND (counter=5) -> immediate IDLE with in_ready_o=1 and out_valid_o=0; the next block produces a correct result.
REQ-041 Build without AES_DECRYPT_EN, present enc_or_dec_i=0 with the C.1 pt -> C.1 ciphertext out.
